ray_gen: RTL and testbench
==========================

# ray_gen

Frame-level ray source for the hit-test stage.
- For each pixel, in raster order, it emits one AXI-stream beat with:
  - the pixel's target point on the image plane, as IEEE-754 float32 coordinates;
  - the matching hcount/vcount;
  - the object-select mask.
- It is the initiator of the ray stream that the object-intersection block consumes.
- It sits between the frame controller (start/done) and the intersection pipeline.
- It honours `tready` backpressure exactly, so the batching consumer can stall it for many cycles per ray.

## Interface
Parameters:
- `SIZE`, 32: float width; only 32 is supported.
- `H_ACTIVE`, 1024: pixels per line, 1..2047.
- `V_ACTIVE`, 768: lines per frame, 1..1023.
- `X_BASE`, -368: signed 16-bit integer x of pixel column 0.
- `Y_BASE`, 534: signed 16-bit integer y of line 0.
- `Z_PLANE`, 0: signed 16-bit integer z of the image plane.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: synchronous, active-low reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `select_objs_in` in 2: object mask, latched at start. Bit 1 = sphere, bit 0 = cylinders.
- `busy` out 1: high in RUN and DRAIN.
- `frame_done` out 1: one-cycle pulse after the last beat is accepted.
- `ray_axis_tdata` out [2:0][SIZE-1:0]: [2]=x, [1]=y, [0]=z, all float32.
- `hcount_axis_tdata` out 11: pixel column.
- `vcount_axis_tdata` out 10: pixel line.
- `select_objs` out 2: latched mask, held constant for the whole frame.
- `ray_axis_tlast` out 1: high on the beat for (H_ACTIVE-1, V_ACTIVE-1).
- `ray_axis_tvalid` out 1: beat valid.
- `ray_axis_tready` in 1: consumer ready.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, `start`=1: latch the mask, clear h=v=0, go to RUN.
  - RUN: while the output slot is free (`!tvalid || tready`), load pixel (h,v) into the output register and advance the counters.
    - h wraps H_ACTIVE-1 → 0 with v+1.
    - After loading (H_ACTIVE-1, V_ACTIVE-1), go to DRAIN.
  - DRAIN: when the final beat handshakes, pulse `frame_done` and go to IDLE.
- `start` outside IDLE is ignored.
- A new `start` in the `frame_done` cycle is accepted, because the FSM is already back in IDLE.
- Coordinate arithmetic, in signed 17-bit integers:
  - x = X_BASE + h
  - y = Y_BASE − v
  - z = Z_PLANE
- Each integer is converted to float32 (round-to-nearest, even on ties).
  - Exact for all parameter-legal ranges, since every value is below 2^24 in magnitude.
  - Zero yields +0 (0x00000000); −0 is never produced.
- Output data is registered; all data fields and `tlast` change only on a load.
- While `tvalid`=1 and `tready`=0, every output stays stable (AXI rule). `tvalid` never drops without a handshake, except on reset.
- Reset mid-frame:
  - the frame is abandoned;
  - the cycle after reset is asserted, `tvalid`=0 and state is IDLE;
  - no `frame_done` pulse is issued.

## Timing
- Reset values: `tvalid`=0, `tlast`=0, all data = 0, `select_objs`=0, `busy`=0, `frame_done`=0.
- `start` in cycle N:
  - `busy` is high from N+1;
  - the first beat (0,0) has `tvalid` high from N+2.
- With `tready` held at 1, the block delivers one beat per cycle, so a frame takes H_ACTIVE·V_ACTIVE cycles of `tvalid`.
- Last handshake in cycle M: `frame_done`=1 and `busy`=0 in cycle M+1.
- Throughput under backpressure: exactly one beat per handshake, with no bubbles other than those caused by `tready`=0.

## Structure
- Shared package:
  - `FLOAT32_ZERO`;
  - a ray-coordinate typedef (`logic [2:0][31:0]`);
  - a select-mask bit-index constant.
- Sub-module `int16_to_float32`: combinational signed-integer to float32 conversion, using leading-zero count plus shift.
  - Instantiated three times, feeding the output register.

## Test plan
Common bench parameters: H_ACTIVE=4, V_ACTIVE=3, X_BASE=-2, Y_BASE=1, Z_PLANE=0.
- Reset, then idle for 10 cycles → `tvalid`=0, `busy`=0, `frame_done` never asserted.
- `start`, `select_objs_in`=2'b11, `tready`=1 → 12 beats in raster order.
  - Beat (0,0): x=0xC0000000, y=0x3F800000, z=0x00000000.
  - Beat (3,1): x=0x3F800000, y=0x00000000.
  - Beat (3,2): y=0xBF800000 and `tlast`=1.
  - `frame_done` one cycle after the 12th handshake.
- Random `tready` (50%) → same 12 beats, no duplicates or drops; data is stable during every stall.
- Change `select_objs_in` and pulse `start` mid-frame → both ignored; all beats carry the original mask.
- Assert `aresetn`=0 at beat 5 → `tvalid`=0 the next cycle. A fresh `start` then restarts from (0,0).
- `start` asserted in the `frame_done` cycle → second frame begins; its first beat is valid two cycles later.

Source files
------------

// File: rtl/ray_gen_pkg.sv
// ray_gen shared types and constants.
// Ray coordinates are float32 triples ordered {x, y, z}.
package ray_gen_pkg;

  localparam logic [31:0] FLOAT32_ZERO = 32'h0000_0000;

  // Bit positions inside the object-select mask
  localparam int SEL_SPHERE = 1;
  localparam int SEL_CYL    = 0;

  typedef logic [2:0][31:0] ray_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/int16_to_float32.sv
// Signed 17-bit integer to float32, exact for |val| <= 2^16.
// Normalises by locating the leading one and shifting.
module int16_to_float32
  import ray_gen_pkg::*;
(
  input  logic signed [16:0] val,
  output logic [31:0]        flt
);

  logic        sign;
  logic [16:0] mag;
  logic [4:0]  msb;
  logic [22:0] frac;

  // Magnitude, leading-one position and shifted fraction
  always_comb begin
    sign = val[16];
    mag  = sign ? 17'(-val) : val;
    msb  = '0;
    for (int i = 0; i < 17; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    frac = 23'({7'b0, mag} << (5'd23 - msb));
    if (mag == '0)
      flt = FLOAT32_ZERO;
    else
      flt = {sign, 8'(8'd127 + 8'(msb)), frac};
  end

endmodule

// File: rtl/ray_gen.sv
// Raster-order ray source: one AXI-stream beat per pixel with
// float32 image-plane target, pixel counts and object mask.
module ray_gen
  import ray_gen_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int X_BASE   = -368,
  parameter int Y_BASE   = 534,
  parameter int Z_PLANE  = 0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [1:0]           select_objs_in,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0][SIZE-1:0] ray_axis_tdata,
  output logic [10:0]          hcount_axis_tdata,
  output logic [9:0]           vcount_axis_tdata,
  output logic [1:0]           select_objs,
  output logic                 ray_axis_tlast,
  output logic                 ray_axis_tvalid,
  input  logic                 ray_axis_tready
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic signed [16:0] XB = 17'(X_BASE);
  localparam logic signed [16:0] YB = 17'(Y_BASE);
  localparam logic signed [16:0] ZP = 17'(Z_PLANE);

  state_t state, state_nxt;
  logic [10:0] h;
  logic [9:0]  v;
  logic        hs;
  logic        load;
  logic        last_pix;
  logic signed [16:0] x_int, y_int;
  ray_t        ray_nxt;

  assign hs       = ray_axis_tvalid && ray_axis_tready;
  assign load     = (state == RUN) && (!ray_axis_tvalid || ray_axis_tready);
  assign last_pix = (h == H_LAST) && (v == V_LAST);
  assign busy     = (state != IDLE);
  assign x_int    = XB + $signed({6'b0, h});
  assign y_int    = YB - $signed({7'b0, v});

  int16_to_float32 u_cvt_x (.val(x_int), .flt(ray_nxt[2]));
  int16_to_float32 u_cvt_y (.val(y_int), .flt(ray_nxt[1]));
  int16_to_float32 u_cvt_z (.val(ZP),    .flt(ray_nxt[0]));

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (load && last_pix) state_nxt = DRAIN;
      DRAIN:   if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel counters and frame mask
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      h           <= '0;
      v           <= '0;
      select_objs <= '0;
    end else if (state == IDLE && start) begin
      h           <= '0;
      v           <= '0;
      select_objs <= {select_objs_in[SEL_SPHERE],
                      select_objs_in[SEL_CYL]};
    end else if (load) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= v + 10'd1;
      end else begin
        h <= h + 11'd1;
      end
    end
  end

  // Output beat register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ray_axis_tdata    <= '0;
      hcount_axis_tdata <= '0;
      vcount_axis_tdata <= '0;
      ray_axis_tlast    <= 1'b0;
      ray_axis_tvalid   <= 1'b0;
    end else if (load) begin
      ray_axis_tdata    <= ray_nxt;
      hcount_axis_tdata <= h;
      vcount_axis_tdata <= v;
      ray_axis_tlast    <= last_pix;
      ray_axis_tvalid   <= 1'b1;
    end else if (hs) begin
      ray_axis_tvalid   <= 1'b0;
    end
  end

  // End-of-frame pulse after the final handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) frame_done <= 1'b0;
    else          frame_done <= (state == DRAIN) && hs;
  end

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen on a 4x3 frame.
// Expected floats are hand-computed constants.
module tb_ray_gen;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        select_objs_in = 2'b00;
  logic              busy;
  logic              frame_done;
  logic [2:0][31:0]  ray_axis_tdata;
  logic [10:0]       hcount_axis_tdata;
  logic [9:0]        vcount_axis_tdata;
  logic [1:0]        select_objs;
  logic              ray_axis_tlast;
  logic              ray_axis_tvalid;
  logic              ray_axis_tready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] ex [4];
  logic [31:0] ey [3];

  ray_gen #(
    .SIZE(32), .H_ACTIVE(4), .V_ACTIVE(3),
    .X_BASE(-2), .Y_BASE(1), .Z_PLANE(0)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
    .select_objs_in(select_objs_in),
    .busy(busy),
    .frame_done(frame_done),
    .ray_axis_tdata(ray_axis_tdata),
    .hcount_axis_tdata(hcount_axis_tdata),
    .vcount_axis_tdata(vcount_axis_tdata),
    .select_objs(select_objs),
    .ray_axis_tlast(ray_axis_tlast),
    .ray_axis_tvalid(ray_axis_tvalid),
    .ray_axis_tready(ray_axis_tready)
  );

  always #5 aclk = ~aclk;

  // Consume beats, checking order, data, mask and stall stability
  task automatic drain_frame(input int mode, input logic [1:0] sel,
                             input int stop_at);
    int beats = 0;
    int cyc = 0;
    int h, v;
    bit stall = 0;
    logic [2:0][31:0] pd;
    logic [10:0] ph;
    logic [9:0] pv;
    logic pl;
    while (beats < stop_at && cyc < 400) begin
      @(negedge aclk);
      cyc++;
      ray_axis_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = 1'b0;
      if (mode == 2 && beats == 5) begin
        start = 1'b1;
        select_objs_in = ~sel;
      end
      if (stall) begin
        total++;
        if ({ray_axis_tdata, hcount_axis_tdata, vcount_axis_tdata,
             ray_axis_tlast, ray_axis_tvalid} !== {pd, ph, pv, pl, 1'b1}) begin
          bad++;
          $display("FAIL stall_stable beat=%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/1",
                   beats, ray_axis_tdata, hcount_axis_tdata,
                   vcount_axis_tdata, ray_axis_tlast, ray_axis_tvalid,
                   pd, ph, pv, pl);
        end
      end
      if (frame_done) begin
        total++;
        bad++;
        $display("FAIL early_done beat=%0d got=1 want=0", beats);
      end
      if (ray_axis_tvalid && ray_axis_tready) begin
        h = beats % 4;
        v = beats / 4;
        total++;
        if (ray_axis_tdata !== {ex[h], ey[v], 32'h0} ||
            hcount_axis_tdata !== 11'(h) ||
            vcount_axis_tdata !== 10'(v) ||
            ray_axis_tlast !== (beats == 11) ||
            select_objs !== sel) begin
          bad++;
          $display("FAIL beat%0d got=%h h=%0d v=%0d last=%b sel=%b want=%h h=%0d v=%0d last=%b sel=%b",
                   beats, ray_axis_tdata, hcount_axis_tdata,
                   vcount_axis_tdata, ray_axis_tlast, select_objs,
                   {ex[h], ey[v], 32'h0}, h, v, (beats == 11), sel);
        end
        beats++;
      end
      stall = ray_axis_tvalid && !ray_axis_tready;
      pd = ray_axis_tdata;
      ph = hcount_axis_tdata;
      pv = vcount_axis_tdata;
      pl = ray_axis_tlast;
    end
    if (beats < stop_at) begin
      total++;
      bad++;
      $display("FAIL timeout got=%0d beats want=%0d", beats, stop_at);
    end
    start = 1'b0;
    select_objs_in = sel;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if ({ray_axis_tdata, hcount_axis_tdata, vcount_axis_tdata, select_objs,
         ray_axis_tlast, ray_axis_tvalid, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_vals got=%h/%0d/%0d/%b/%b/%b/%b/%b want=all zero",
               ray_axis_tdata, hcount_axis_tdata, vcount_axis_tdata,
               select_objs, ray_axis_tlast, ray_axis_tvalid, busy, frame_done);
    end
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      total++;
      if ({ray_axis_tvalid, busy, frame_done} !== 3'b000) begin
        bad++;
        $display("FAIL idle%0d got=%b want=000", i,
                 {ray_axis_tvalid, busy, frame_done});
      end
    end
  endtask

  task automatic test_frame();
    @(negedge aclk);
    start = 1'b1;
    select_objs_in = 2'b11;
    ray_axis_tready = 1'b0;
    @(negedge aclk);
    start = 1'b0;
    total++;
    if ({busy, ray_axis_tvalid} !== 2'b10) begin
      bad++;
      $display("FAIL start_n1 got=%b want=10", {busy, ray_axis_tvalid});
    end
    @(negedge aclk);
    total++;
    if (ray_axis_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL start_n2 tvalid got=%b want=1", ray_axis_tvalid);
    end
    drain_frame(0, 2'b11, 12);
    @(negedge aclk);
    total++;
    if ({frame_done, busy, ray_axis_tvalid} !== 3'b100) begin
      bad++;
      $display("FAIL done_pulse got=%b want=100",
               {frame_done, busy, ray_axis_tvalid});
    end
    @(negedge aclk);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL done_width got=%b want=0", frame_done);
    end
  endtask

  task automatic test_backpressure();
    @(negedge aclk);
    start = 1'b1;
    select_objs_in = 2'b01;
    drain_frame(1, 2'b01, 12);
    @(negedge aclk);
    total++;
    if ({frame_done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL bp_done got=%b want=10", {frame_done, busy});
    end
  endtask

  task automatic test_ignore_start();
    @(negedge aclk);
    start = 1'b1;
    select_objs_in = 2'b10;
    drain_frame(2, 2'b10, 12);
    @(negedge aclk);
    total++;
    if ({frame_done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL ign_done got=%b want=10", {frame_done, busy});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    start = 1'b1;
    select_objs_in = 2'b11;
    drain_frame(0, 2'b11, 5);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    total++;
    if ({ray_axis_tvalid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid got=%b want=000",
               {ray_axis_tvalid, busy, frame_done});
    end
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      total++;
      if ({ray_axis_tvalid, frame_done} !== 2'b00) begin
        bad++;
        $display("FAIL rst_quiet%0d got=%b want=00", i,
                 {ray_axis_tvalid, frame_done});
      end
    end
    start = 1'b1;
    drain_frame(0, 2'b11, 12);
    @(negedge aclk);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_redo_done got=%b want=1", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge aclk);
    start = 1'b1;
    select_objs_in = 2'b01;
    drain_frame(0, 2'b01, 12);
    @(negedge aclk);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done1 got=%b want=1", frame_done);
    end
    start = 1'b1;
    ray_axis_tready = 1'b0;
    @(negedge aclk);
    start = 1'b0;
    total++;
    if ({busy, ray_axis_tvalid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_n1 got=%b want=10", {busy, ray_axis_tvalid});
    end
    @(negedge aclk);
    total++;
    if ({ray_axis_tvalid, hcount_axis_tdata, vcount_axis_tdata} !==
        {1'b1, 11'd0, 10'd0}) begin
      bad++;
      $display("FAIL b2b_n2 got=%b/%0d/%0d want=1/0/0", ray_axis_tvalid,
               hcount_axis_tdata, vcount_axis_tdata);
    end
    drain_frame(0, 2'b01, 12);
    @(negedge aclk);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done2 got=%b want=1", frame_done);
    end
  endtask

  initial begin
    ex[0] = 32'hC000_0000;
    ex[1] = 32'hBF80_0000;
    ex[2] = 32'h0000_0000;
    ex[3] = 32'h3F80_0000;
    ey[0] = 32'h3F80_0000;
    ey[1] = 32'h0000_0000;
    ey[2] = 32'hBF80_0000;
    test_reset();
    test_frame();
    test_backpressure();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
